// File: rtl/clk_step_divider_if.sv
// Control and status bundle between the debug/halt logic and the clock divider.
// The master side drives divisor and run control; the slave side returns clock status.
interface clk_step_divider_if #(
    parameter int CNT_W = 16
);
    logic             div_load;
    logic [CNT_W-1:0] div_val;
    logic             fast_mode;
    logic             halt;
    logic             step_req;
    logic             step_ack;
    logic             clk_out;
    logic             tick_rise;
    logic             running;

    modport master (
        output div_load, div_val, fast_mode, halt, step_req,
        input  step_ack, clk_out, tick_rise, running
    );

    modport slave (
        input  div_load, div_val, fast_mode, halt, step_req,
        output step_ack, clk_out, tick_rise, running
    );
endinterface

// File: rtl/clk_step_divider.sv
// Programmable clock-enable divider producing the slow core clock,
// with halt-and-park (clk_out held high) and single-step debug support.
module clk_step_divider #(
    parameter int CNT_W       = 16,
    parameter int DIV_DEFAULT = 5
) (
    input logic               clk,
    input logic               reset,
    clk_step_divider_if.slave bus
);
    localparam logic [1:0] RUN    = 2'd0;
    localparam logic [1:0] PARKED = 2'd1;
    localparam logic [1:0] STEP   = 2'd2;

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic [CNT_W-1:0] div_reg;
    logic [CNT_W-1:0] eff_div;
    logic             toggle;
    logic             clk_nxt;
    logic             rise_nxt;
    logic             ack_nxt;

    assign eff_div = bus.fast_mode ? '0 : div_reg;
    // Comparing with >= lets a shrinking divisor toggle at once instead of wrapping
    assign toggle  = count >= eff_div;

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        clk_nxt   = bus.clk_out;
        rise_nxt  = 1'b0;
        ack_nxt   = 1'b0;
        unique case (1'b1)
            state == RUN: begin
                if (bus.halt && bus.clk_out) begin
                    state_nxt = PARKED;
                end else if (toggle) begin
                    count_nxt = '0;
                    clk_nxt   = ~bus.clk_out;
                    rise_nxt  = ~bus.clk_out;
                    if (bus.halt && !bus.clk_out) begin
                        state_nxt = PARKED;
                    end
                end else begin
                    count_nxt = count + ONE;
                end
            end
            state == PARKED: begin
                if (!bus.halt) begin
                    state_nxt = RUN;
                    count_nxt = '0;
                end else if (bus.step_req) begin
                    state_nxt = STEP;
                    count_nxt = '0;
                end
            end
            state == STEP: begin
                if (toggle) begin
                    count_nxt = '0;
                    clk_nxt   = ~bus.clk_out;
                    // A step starts high, so its only 0->1 edge is the last one
                    if (!bus.clk_out) begin
                        rise_nxt  = 1'b1;
                        ack_nxt   = 1'b1;
                        state_nxt = bus.halt ? PARKED : RUN;
                    end
                end else begin
                    count_nxt = count + ONE;
                end
            end
            default: begin
                state_nxt = RUN;
                count_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= RUN;
            count         <= '0;
            div_reg       <= DIV_RST;
            bus.clk_out   <= 1'b0;
            bus.tick_rise <= 1'b0;
            bus.step_ack  <= 1'b0;
            bus.running   <= 1'b1;
        end else begin
            state         <= state_nxt;
            count         <= count_nxt;
            bus.clk_out   <= clk_nxt;
            bus.tick_rise <= rise_nxt;
            bus.step_ack  <= ack_nxt;
            bus.running   <= state_nxt != PARKED;
            if (bus.div_load) begin
                div_reg <= bus.div_val;
            end
        end
    end
endmodule

// File: tb/tb_clk_step_divider.sv
// Self-checking bench for clk_step_divider: per-cycle scoreboard sequences
// plus a table of divisor settings measured by phase length.
module tb_clk_step_divider;
    localparam int CNT_W = 16;

    logic clk;
    logic reset;

    clk_step_divider_if #(.CNT_W(CNT_W)) bus();

    clk_step_divider #(
        .CNT_W      (CNT_W),
        .DIV_DEFAULT(5)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic c;
        logic r;
        logic u;
        logic a;
    } obs_t;

    typedef struct {
        logic             fast;
        logic [CNT_W-1:0] div;
        int               half;
    } vec_t;

    obs_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_out(input string name);
        obs_t exp;
        obs_t got;
        got = {bus.clk_out, bus.tick_rise, bus.running, bus.step_ack};
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s scoreboard empty, got=%b", name, got);
        end else begin
            exp = sb.pop_front();
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s t=%0t got clk/rise/run/ack=%b want=%b",
                         name, $time, got, exp);
            end
        end
    endtask

    task automatic seg(input string name, input int n,
                       input logic c, input logic r,
                       input logic u, input logic a);
        for (int i = 0; i < n; i++) begin
            sb.push_back('{c, r, u, a});
            @(posedge clk);
            #1;
            check_out(name);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_int(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    vec_t vecs[5];

    initial begin
        int hi;
        int lo;
        int waited;

        vecs[0] = '{fast: 1'b0, div: 16'd0, half: 1};
        vecs[1] = '{fast: 1'b0, div: 16'd3, half: 4};
        vecs[2] = '{fast: 1'b1, div: 16'd7, half: 1};
        vecs[3] = '{fast: 1'b0, div: 16'd7, half: 8};
        vecs[4] = '{fast: 1'b0, div: 16'd5, half: 6};

        reset         = 1'b1;
        bus.div_load  = 1'b0;
        bus.div_val   = '0;
        bus.fast_mode = 1'b0;
        bus.halt      = 1'b0;
        bus.step_req  = 1'b0;

        seg("reset", 2, 0, 0, 1, 0);
        reset = 1'b0;

        // default divisor: first rise 6 cycles after release, period 12
        seg("first_low", 5, 0, 0, 1, 0);
        seg("first_rise", 1, 1, 1, 1, 0);
        seg("hi0", 5, 1, 0, 1, 0);
        seg("fall0", 1, 0, 0, 1, 0);
        seg("lo0", 5, 0, 0, 1, 0);
        seg("rise1", 1, 1, 1, 1, 0);

        // load divisor 2 while count is 4: toggle follows on next cycle
        seg("pre_load", 4, 1, 0, 1, 0);
        bus.div_load = 1'b1;
        bus.div_val  = 16'd2;
        seg("load_cyc", 1, 1, 0, 1, 0);
        bus.div_load = 1'b0;
        seg("load_fall", 1, 0, 0, 1, 0);
        seg("d2_lo", 2, 0, 0, 1, 0);
        seg("d2_rise", 1, 1, 1, 1, 0);
        seg("d2_hi", 2, 1, 0, 1, 0);
        seg("d2_fall", 1, 0, 0, 1, 0);
        seg("d2_lo2", 2, 0, 0, 1, 0);
        seg("d2_rise2", 1, 1, 1, 1, 0);

        // divisor / fast-mode table
        for (int v = 0; v < 5; v++) begin
            bus.div_load  = 1'b1;
            bus.div_val   = vecs[v].div;
            bus.fast_mode = vecs[v].fast;
            cyc();
            bus.div_load = 1'b0;
            waited = 0;
            while (!bus.tick_rise && waited < 200) begin
                cyc();
                waited++;
            end
            if (waited >= 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL tbl%0d_sync no tick_rise within 200 cycles", v);
            end
            hi = 1;
            cyc();
            while (bus.clk_out && hi < 200) begin
                hi++;
                cyc();
            end
            lo = 1;
            cyc();
            while (!bus.clk_out && lo < 200) begin
                lo++;
                cyc();
            end
            check_int($sformatf("tbl%0d_high", v), hi, vecs[v].half);
            check_int($sformatf("tbl%0d_low", v), lo, vecs[v].half);
            check_int($sformatf("tbl%0d_rise", v), int'(bus.tick_rise), 1);
        end

        // halt while low: run to the rise, then park for 50 cycles
        seg("pre_halt_hi", 5, 1, 0, 1, 0);
        seg("pre_halt_fall", 1, 0, 0, 1, 0);
        bus.halt = 1'b1;
        seg("halt_lo", 5, 0, 0, 1, 0);
        seg("halt_rise", 1, 1, 1, 0, 0);
        seg("parked", 50, 1, 0, 0, 0);

        // single step, with a second request ignored mid-step
        bus.step_req = 1'b1;
        seg("step_req", 1, 1, 0, 1, 0);
        bus.step_req = 1'b0;
        seg("step_hi_a", 2, 1, 0, 1, 0);
        bus.step_req = 1'b1;
        seg("step_hi_b", 1, 1, 0, 1, 0);
        bus.step_req = 1'b0;
        seg("step_hi_c", 2, 1, 0, 1, 0);
        seg("step_fall", 1, 0, 0, 1, 0);
        seg("step_lo", 5, 0, 0, 1, 0);
        seg("step_ack", 1, 1, 1, 0, 1);
        seg("reparked", 10, 1, 0, 0, 0);

        // reset three cycles into a step, halt held
        bus.step_req = 1'b1;
        seg("step2_req", 1, 1, 0, 1, 0);
        bus.step_req = 1'b0;
        seg("step2_hi", 2, 1, 0, 1, 0);
        reset = 1'b1;
        seg("step_reset", 1, 0, 0, 1, 0);
        reset = 1'b0;
        seg("rst_lo", 5, 0, 0, 1, 0);
        seg("rst_repark", 1, 1, 1, 0, 0);
        seg("rst_parked", 5, 1, 0, 0, 0);

        // release and step together: release wins, no step_ack
        bus.halt     = 1'b0;
        bus.step_req = 1'b1;
        seg("rel_step", 1, 1, 0, 1, 0);
        bus.step_req = 1'b0;
        seg("rel_hi", 5, 1, 0, 1, 0);
        seg("rel_fall", 1, 0, 0, 1, 0);
        seg("rel_lo_a", 2, 0, 0, 1, 0);
        bus.step_req = 1'b1;
        seg("run_stepreq", 1, 0, 0, 1, 0);
        bus.step_req = 1'b0;
        seg("rel_lo_b", 2, 0, 0, 1, 0);
        seg("rel_rise", 1, 1, 1, 1, 0);

        // halt while high freezes; release resumes from count 0
        seg("hh_pre", 2, 1, 0, 1, 0);
        bus.halt = 1'b1;
        seg("hh_park", 4, 1, 0, 0, 0);
        bus.halt = 1'b0;
        seg("hh_resume", 1, 1, 0, 1, 0);
        seg("hh_hi", 5, 1, 0, 1, 0);
        seg("hh_fall", 1, 0, 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
